scan_chain_ctrl: RTL and testbench
==================================

// Module: scan_chain_ctrl
// PURPOSE
//  Drives a serial scan chain of fd4e-style cells (d/cp/sd/ti/te, cp sampled on sys_clk).
//  Generates the scan_cp enable pulses, scan_te, scan_ti and scan_sdn for the chain.
//  Loads a parallel word into the chain and returns the old chain contents in parallel.
//  Can optionally capture functional d inputs first. Sits between the debug/host register block and the chain.
// PARAMETERS
//  CHAIN_LEN  16  cells in chain (>=2); chain cell i ti = cell i-1 q, cell 0 ti = scan_ti, scan_so = cell CHAIN_LEN-1 q
//  PULSE_GAP  1   sys_clk cycles with scan_cp=0 between consecutive scan_cp pulses (>=1)
// PORTS
//  sys_clk      in   1          system clock; all state on posedge
//  sys_rst      in   1          asynchronous reset, active-high
//  start        in   1          request scan op; accepted only in IDLE
//  cap_en       in   1          sampled with start: 1 = capture pulse (te=0) before shifting
//  load_data    in   CHAIN_LEN  word shifted in; sampled with start; cell i receives load_data[i]
//  chain_clear  in   1          IDLE only: pulse scan_sdn low 1 cycle (chain cells -> 1)
//  busy         out  1          1 whenever state != IDLE
//  done         out  1          1-cycle pulse; unload_data valid from this cycle until next accepted start
//  unload_data  out  CHAIN_LEN  prior chain contents; bit i = cell i
//  scan_cp      out  1          registered chain clock-enable pulse
//  scan_te      out  1          registered test-enable (1 = shift)
//  scan_ti      out  1          serial data to cell 0
//  scan_sdn     out  1          registered active-low chain set
//  scan_so      in   1          serial data from last cell (combinational from its q)
// BEHAVIOUR
//  Reset (async, immediate): state IDLE, busy=0, done=0, scan_cp=0, scan_te=0, scan_sdn=1, unload_data=0,
//   internal shift reg=0. Chain contents after reset mid-operation: undefined, not repaired.
//  States: IDLE, CLEAR, CAPTURE, CAP_GAP, SETUP, SHIFT, GAP, DONE.
//  IDLE: chain_clear=1 -> CLEAR (scan_sdn=0 one cycle) -> IDLE. chain_clear has priority; start in the same cycle is dropped.
//  IDLE: start=1 (no clear) -> sr <= load_data. Next state: CAPTURE if cap_en, else SETUP.
//   Cycle 0 = the start edge.
//  CAPTURE: scan_cp=1, scan_te=0 for 1 cycle. Then CAP_GAP: PULSE_GAP cycles, cp=0, te=0. Then SETUP.
//  SETUP: 1 cycle, scan_te=1, scan_cp=0, scan_ti=sr[CHAIN_LEN-1].
//  SHIFT pulse j (j=0..CHAIN_LEN-1): scan_cp=1, scan_te=1, scan_ti=sr[CHAIN_LEN-1].
//   On that edge the chain shifts and sr <= {sr[CHAIN_LEN-2:0], scan_so}.
//   scan_so is sampled on the same edge the chain updates, i.e. its pre-shift value.
//  Between pulses: GAP state for PULSE_GAP cycles, cp=0, te=1, ti holds new sr MSB.
//  Pulse timing: setup cycle S = 1 + (cap_en ? PULSE_GAP+1 : 0); pulse j at S+1+j*(PULSE_GAP+1).
//  DONE: cycle after pulse CHAIN_LEN-1. done=1, busy=1, te=0, cp=0, unload_data <= sr. Next cycle -> IDLE.
//  start / chain_clear while busy (including the DONE cycle): ignored, no queueing.
//  scan_cp is never high in two consecutive cycles. scan_te changes only in cycles where scan_cp=0.
//  Counter: $clog2(CHAIN_LEN+1) bits for pulses and $clog2(PULSE_GAP+1) bits for gap; no wrap within an op.
// TESTING (bench models CHAIN_LEN fd4e cells on sys_clk; CHAIN_LEN=4, PULSE_GAP=1 unless noted)
//  1 Async reset asserted mid-cycle -> outputs take reset values before the next edge.
//    unload_data=0, scan_sdn=1, busy=0.
//  2 Chain preset 4'b1010, start with load_data=4'b0011, cap_en=0 -> te=1 cycle 1.
//    cp pulses at cycles 2,4,6,8; done at cycle 9; unload_data=4'b1010; chain=4'b0011.
//  3 Cell d inputs=4'b0110, cap_en=1, load_data=4'b1111 -> cp with te=0 at cycle 1, setup at cycle 3.
//    Pulses at cycles 4..10; done at cycle 11; unload_data=4'b0110.
//  4 chain_clear and start together in IDLE -> scan_sdn=0 for 1 cycle, start dropped, chain=4'b1111.
//    A following start with load_data=0 unloads 4'b1111.
//  5 start held high continuously -> second op accepted only on the cycle after done.
//    chain_clear pulsed during SHIFT is ignored.
//  6 PULSE_GAP=3, CHAIN_LEN=16, random load/preset -> cp period 4 cycles, te stable around pulses.
//    unload_data equals preset; chain equals load_data.
//  7 sys_rst asserted between pulse 1 and pulse 2 -> busy=0 and scan_cp=0 immediately.
//    A new start then completes correctly with the same timing as test 2.

Source files
------------

// File: rtl/scan_chain_ctrl.sv
// Scan chain controller: loads a parallel word into a serial chain of fd4e-style cells,
// optionally capturing functional data first, and returns the previous chain contents.
module scan_chain_ctrl #(
    parameter int unsigned CHAIN_LEN = 16,
    parameter int unsigned PULSE_GAP = 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 start,
    input  logic                 cap_en,
    input  logic [CHAIN_LEN-1:0] load_data,
    input  logic                 chain_clear,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] unload_data,
    output logic                 scan_cp,
    output logic                 scan_te,
    output logic                 scan_ti,
    output logic                 scan_sdn,
    input  logic                 scan_so
);

    localparam int unsigned PCW = $clog2(CHAIN_LEN + 1);
    localparam int unsigned GCW = $clog2(PULSE_GAP + 1);
    localparam logic [PCW-1:0] LastPulse = PCW'(CHAIN_LEN - 1);
    localparam logic [GCW-1:0] LastGap   = GCW'(PULSE_GAP - 1);

    typedef enum logic [2:0] {
        StIdle, StClear, StCapture, StCapGap, StSetup, StShift, StGap, StDone
    } state_e;

    state_e               state_q, state_d;
    logic [CHAIN_LEN-1:0] sr_q, sr_d;
    logic [CHAIN_LEN-1:0] unload_q, unload_d;
    logic [PCW-1:0]       pulse_cnt_q, pulse_cnt_d;
    logic [GCW-1:0]       gap_cnt_q, gap_cnt_d;
    logic                 cp_q, cp_d;
    logic                 te_q, te_d;
    logic                 sdn_q, sdn_d;
    logic                 done_q, done_d;
    logic [CHAIN_LEN-1:0] shifted;

    // scan_so is the pre-shift value of the last cell, sampled on the pulse edge.
    assign shifted     = {sr_q[CHAIN_LEN-2:0], scan_so};
    assign scan_ti     = sr_q[CHAIN_LEN-1];
    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign unload_data = unload_q;
    assign scan_cp     = cp_q;
    assign scan_te     = te_q;
    assign scan_sdn    = sdn_q;

    // Next-state, datapath and next-cycle chain controls (decoded from state_d so they register).
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        unload_d    = unload_q;
        pulse_cnt_d = pulse_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (chain_clear) begin
                    state_d = StClear;
                end else if (start) begin
                    sr_d        = load_data;
                    pulse_cnt_d = '0;
                    gap_cnt_d   = '0;
                    state_d     = cap_en ? StCapture : StSetup;
                end
            end
            StClear:   state_d = StIdle;
            StCapture: begin
                gap_cnt_d = '0;
                state_d   = StCapGap;
            end
            StCapGap: begin
                if (gap_cnt_q == LastGap) state_d = StSetup;
                else                      gap_cnt_d = gap_cnt_q + 1'b1;
            end
            StSetup:   state_d = StShift;
            StShift: begin
                sr_d        = shifted;
                gap_cnt_d   = '0;
                pulse_cnt_d = pulse_cnt_q + 1'b1;
                if (pulse_cnt_q == LastPulse) begin
                    // Capture here so unload_data is already valid in the DONE cycle.
                    unload_d = shifted;
                    state_d  = StDone;
                end else begin
                    state_d = StGap;
                end
            end
            StGap: begin
                if (gap_cnt_q == LastGap) state_d = StShift;
                else                      gap_cnt_d = gap_cnt_q + 1'b1;
            end
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase

        cp_d   = (state_d == StCapture) || (state_d == StShift);
        te_d   = (state_d == StSetup) || (state_d == StShift) || (state_d == StGap);
        sdn_d  = (state_d != StClear);
        done_d = (state_d == StDone);
    end

    // State and registered outputs; reset returns the controller to idle immediately.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= StIdle;
            sr_q        <= '0;
            unload_q    <= '0;
            pulse_cnt_q <= '0;
            gap_cnt_q   <= '0;
            cp_q        <= 1'b0;
            te_q        <= 1'b0;
            sdn_q       <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            unload_q    <= unload_d;
            pulse_cnt_q <= pulse_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            cp_q        <= cp_d;
            te_q        <= te_d;
            sdn_q       <= sdn_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: two instances (4 cells/gap 1 and 16 cells/gap 3), each driving
// a behavioural fd4e chain; expected unload/chain words go through a scoreboard queue.
module tb_scan_chain_ctrl;

    logic sys_clk = 1'b0;
    logic sys_rst;
    always #5 sys_clk = ~sys_clk;

    // Small instance
    logic        start4, cap_en4, clr4;
    logic [3:0]  ld4, un4;
    logic        busy4, done4, cp4, te4, ti4, sdn4, so4;
    // Large instance
    logic        start16, cap_en16, clr16;
    logic [15:0] ld16, un16;
    logic        busy16, done16, cp16, te16, ti16, sdn16, so16;

    scan_chain_ctrl #(.CHAIN_LEN(4), .PULSE_GAP(1)) u_dut4 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start4), .cap_en(cap_en4),
        .load_data(ld4), .chain_clear(clr4), .busy(busy4), .done(done4), .unload_data(un4),
        .scan_cp(cp4), .scan_te(te4), .scan_ti(ti4), .scan_sdn(sdn4), .scan_so(so4)
    );

    scan_chain_ctrl #(.CHAIN_LEN(16), .PULSE_GAP(3)) u_dut16 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start16), .cap_en(cap_en16),
        .load_data(ld16), .chain_clear(clr16), .busy(busy16), .done(done16), .unload_data(un16),
        .scan_cp(cp16), .scan_te(te16), .scan_ti(ti16), .scan_sdn(sdn16), .scan_so(so16)
    );

    // Behavioural fd4e chains: cell 0 takes scan_ti, cell i takes cell i-1, sdn sets to 1.
    logic [3:0]  c4, d4, pre4;
    logic [15:0] c16, d16, pre16;
    logic        pre_en4, pre_en16;

    always_ff @(posedge sys_clk or negedge sdn4) begin
        if (!sdn4)        c4 <= '1;
        else if (pre_en4) c4 <= pre4;
        else if (cp4)     c4 <= te4 ? {c4[2:0], ti4} : d4;
    end
    assign so4 = c4[3];

    always_ff @(posedge sys_clk or negedge sdn16) begin
        if (!sdn16)        c16 <= '1;
        else if (pre_en16) c16 <= pre16;
        else if (cp16)     c16 <= te16 ? {c16[14:0], ti16} : d16;
    end
    assign so16 = c16[15];

    // Observation mux onto whichever instance the current operation targets
    logic        sel16;
    logic        obs_cp, obs_te, obs_busy, obs_done, obs_sdn;
    logic [15:0] obs_un, obs_chain;
    assign obs_cp    = sel16 ? cp16   : cp4;
    assign obs_te    = sel16 ? te16   : te4;
    assign obs_busy  = sel16 ? busy16 : busy4;
    assign obs_done  = sel16 ? done16 : done4;
    assign obs_sdn   = sel16 ? sdn16  : sdn4;
    assign obs_un    = sel16 ? un16   : {12'b0, un4};
    assign obs_chain = sel16 ? c16    : {12'b0, c4};

    typedef struct {
        logic [15:0] unload;
        logic [15:0] chain;
        int          done_cyc;
    } exp_t;
    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic big, input logic s, input logic c, input logic [15:0] ld,
                         input logic clr);
        if (big) begin
            start16 = s; cap_en16 = c; ld16 = ld; clr16 = clr;
        end else begin
            start4 = s; cap_en4 = c; ld4 = ld[3:0]; clr4 = clr;
        end
    endtask

    task automatic preset(input logic big, input logic [15:0] v);
        @(negedge sys_clk);
        if (big) begin pre16 = v; pre_en16 = 1'b1; end
        else     begin pre4 = v[3:0]; pre_en4 = 1'b1; end
        @(negedge sys_clk);
        pre_en4  = 1'b0;
        pre_en16 = 1'b0;
    endtask

    // One scan op. hold keeps start high; clr_at pulses chain_clear in that cycle;
    // abort_at asserts sys_rst mid-cycle in that cycle and checks the immediate reset values.
    task automatic run_op(input logic big, input logic cap, input logic [15:0] ld,
                          input logic [15:0] exp_un, input logic hold, input int clr_at,
                          input int abort_at);
        int   len, gap, s_cyc, last, dn;
        logic pulse, te;
        exp_t e;
        sel16 = big;
        len   = big ? 16 : 4;
        gap   = big ? 3 : 1;
        s_cyc = 1 + (cap ? gap + 1 : 0);
        last  = s_cyc + 1 + (len - 1) * (gap + 1);
        dn    = last + 1;
        @(negedge sys_clk);
        check("idle_before_start", 32'(obs_busy), 32'd0);
        drive(big, 1'b1, cap, ld, 1'b0);
        e.unload   = exp_un;
        e.chain    = big ? ld : {12'b0, ld[3:0]};
        e.done_cyc = dn;
        sb.push_back(e);
        @(posedge sys_clk);
        #1 drive(big, hold, cap, ld, 1'b0);
        for (int cyc = 1; cyc <= dn; cyc++) begin
            @(negedge sys_clk);
            pulse = (cap && cyc == 1) ||
                    (cyc > s_cyc && cyc <= last && ((cyc - s_cyc - 1) % (gap + 1)) == 0);
            te    = (cyc >= s_cyc && cyc < dn);
            check($sformatf("ctl_c%0d cp/te/busy/done/sdn", cyc),
                  32'({obs_cp, obs_te, obs_busy, obs_done, obs_sdn}),
                  32'({pulse, te, 1'b1, (cyc == dn), 1'b1}));
            drive(big, hold, cap, ld, (cyc == clr_at));
            if (cyc == abort_at) begin
                #1 sys_rst = 1'b1;
                #1;
                check("rst_busy/cp/done/te/sdn",
                      32'({obs_busy, obs_cp, obs_done, obs_te, obs_sdn}), 32'b00001);
                check("rst_unload", 32'(obs_un), 32'd0);
                e = sb.pop_back();
                drive(big, 1'b0, 1'b0, ld, 1'b0);
                return;
            end
        end
        e = sb.pop_front();
        check("done_cyc", 32'(dn), 32'(e.done_cyc));
        check("unload", 32'(obs_un), 32'(e.unload));
        check("chain", 32'(obs_chain), 32'(e.chain));
        drive(big, hold, cap, ld, 1'b0);
    endtask

    initial begin
        logic [15:0] r_pre, r_ld;
        sys_rst = 1'b1;
        sel16   = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        pre4 = '0; pre16 = '0; pre_en4 = 1'b0; pre_en16 = 1'b0;
        d4 = '0; d16 = '0;
        repeat (2) @(negedge sys_clk);
        check("reset4 busy/done/cp/te/sdn", 32'({busy4, done4, cp4, te4, sdn4}), 32'b00001);
        check("reset4 unload", 32'(un4), 32'd0);
        check("reset16 busy/done/cp/te/sdn", 32'({busy16, done16, cp16, te16, sdn16}), 32'b00001);
        check("reset16 unload", 32'(un16), 32'd0);
        sys_rst = 1'b0;

        // Plain load/unload
        preset(1'b0, 16'hA);
        run_op(1'b0, 1'b0, 16'h3, 16'hA, 1'b0, 0, 0);

        // Capture functional inputs first
        d4 = 4'b0110;
        run_op(1'b0, 1'b1, 16'hF, 16'h6, 1'b0, 0, 0);

        // chain_clear wins over a simultaneous start
        preset(1'b0, 16'h0);
        @(negedge sys_clk);
        drive(1'b0, 1'b1, 1'b0, 16'h5, 1'b1);
        @(posedge sys_clk);
        #1 drive(1'b0, 1'b0, 1'b0, 16'h5, 1'b0);
        @(negedge sys_clk);
        check("clear_cyc sdn/busy", 32'({sdn4, busy4}), 32'b01);
        @(negedge sys_clk);
        check("after_clear sdn/busy", 32'({sdn4, busy4}), 32'b10);
        check("clear_chain", 32'(c4), 32'hF);
        run_op(1'b0, 1'b0, 16'h0, 16'hF, 1'b0, 0, 0);

        // start held high across two ops; chain_clear during SHIFT ignored
        run_op(1'b0, 1'b0, 16'h9, 16'h0, 1'b1, 4, 0);
        run_op(1'b0, 1'b0, 16'h6, 16'h9, 1'b0, 0, 0);

        // Reset between pulse 1 and pulse 2, then a clean op
        preset(1'b0, 16'hC);
        run_op(1'b0, 1'b0, 16'h5, 16'hC, 1'b0, 0, 5);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        preset(1'b0, 16'h3);
        run_op(1'b0, 1'b0, 16'hA, 16'h3, 1'b0, 0, 0);

        // Long chain, wide gap
        r_pre = 16'($urandom);
        r_ld  = 16'($urandom);
        preset(1'b1, r_pre);
        run_op(1'b1, 1'b0, r_ld, r_pre, 1'b0, 0, 0);
        d16  = 16'($urandom);
        r_ld = 16'($urandom);
        run_op(1'b1, 1'b1, r_ld, d16, 1'b0, 0, 0);

        repeat (2) @(negedge sys_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
